// File: rtl/multi_channel_edge_delay.sv
// multi_channel_edge_delay
// N_CH independent lines, each re-timed by a programmable rising/falling edge
// delay. Per channel: commit mode reproduces every detected edge, filter mode
// discards an edge whose input reverts before the delay expires and records
// that in a sticky glitch flag.
module multi_channel_edge_delay #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [N_CH-1:0]         signal_in,
  input  logic [N_CH*CNT_W-1:0]   rising_delay_in,
  input  logic [N_CH*CNT_W-1:0]   falling_delay_in,
  input  logic [N_CH-1:0]         filter_mode_in,
  input  logic                    glitch_clr_in,
  output logic [N_CH-1:0]         signal_out,
  output logic [N_CH-1:0]         busy_out,
  output logic [N_CH-1:0]         glitch_out
);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_DLY = 2'd1,
    HIGH     = 2'd2,
    FALL_DLY = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Registered copy of the raw lines; the per-channel FSMs only ever see this.
  logic [N_CH-1:0] s_q;

  // Input stage: sample every line on each clock edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s_q <= {N_CH{1'b0}};
    end else begin
      s_q <= signal_in;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] rise_d;
    logic [CNT_W-1:0] fall_d;
    logic             out_q;
    logic             out_nxt;
    logic             glitch_q;
    logic             glitch_set;

    assign rise_d = rising_delay_in[i*CNT_W +: CNT_W];
    assign fall_d = falling_delay_in[i*CNT_W +: CNT_W];

    // Next-state, counter and output decision for this channel.
    always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      out_nxt    = out_q;
      glitch_set = 1'b0;
      case (state)
        LOW: begin
          out_nxt = 1'b0;
          if (s_q[i]) begin
            if (rise_d == CNT_ZERO) begin
              out_nxt   = 1'b1;
              state_nxt = HIGH;
            end else begin
              cnt_nxt   = rise_d;
              state_nxt = RISE_DLY;
            end
          end else begin
            state_nxt = LOW;
          end
        end
        RISE_DLY: begin
          // Filter mode: input fell back before the delay ran out.
          if (filter_mode_in[i] && !s_q[i]) begin
            state_nxt  = LOW;
            glitch_set = 1'b1;
          end else if (cnt == CNT_ONE) begin
            out_nxt   = 1'b1;
            state_nxt = HIGH;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        HIGH: begin
          out_nxt = 1'b1;
          if (!s_q[i]) begin
            if (fall_d == CNT_ZERO) begin
              out_nxt   = 1'b0;
              state_nxt = LOW;
            end else begin
              cnt_nxt   = fall_d;
              state_nxt = FALL_DLY;
            end
          end else begin
            state_nxt = HIGH;
          end
        end
        FALL_DLY: begin
          // Filter mode: input rose back before the delay ran out.
          if (filter_mode_in[i] && s_q[i]) begin
            state_nxt  = HIGH;
            glitch_set = 1'b1;
          end else if (cnt == CNT_ONE) begin
            out_nxt   = 1'b0;
            state_nxt = LOW;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        default: begin
          state_nxt = LOW;
          cnt_nxt   = CNT_ZERO;
          out_nxt   = 1'b0;
        end
      endcase
    end

    // State, delay counter and delayed output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        state <= LOW;
        cnt   <= CNT_ZERO;
        out_q <= 1'b0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        out_q <= out_nxt;
      end
    end

    // Sticky glitch flag; a new abort on the same edge as a clear keeps it set.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        glitch_q <= 1'b0;
      end else if (glitch_set) begin
        glitch_q <= 1'b1;
      end else if (glitch_clr_in) begin
        glitch_q <= 1'b0;
      end else begin
        glitch_q <= glitch_q;
      end
    end

    assign signal_out[i] = out_q;
    assign busy_out[i]   = (state == RISE_DLY) || (state == FALL_DLY);
    assign glitch_out[i] = glitch_q;
  end

endmodule
